mem_store_buffer: RTL and testbench

Posted-store buffer between the MEM-stage request port and `Data_Memory`. Stores are queued in a small FIFO and drained to memory one per cycle, whenever the memory port is not needed by a load. Loads check the buffer first: a hit is forwarded from the youngest matching entry, and a miss reads `Data_Memory` directly. Memory-side outputs drive `Data_Memory`'s `data1_i`/`data2_i`/`Mem_Read_i`/`Mem_Write_i`; its combinational `data_o` returns on `mem_rdata_i`.

---
 rtl/mem_store_buffer.sv | 137 +++++++++++++
 tb/tb_mem_store_buffer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_store_buffer.sv
// Posted-store buffer between the MEM-stage request port and Data_Memory.
// Stores queue in a FIFO and drain one per cycle; loads forward from the youngest match.
module mem_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    input  logic                     req_write_i,
    input  logic [AW-1:0]            req_addr_i,
    input  logic [DW-1:0]            req_wdata_i,
    output logic                     req_ready_o,
    output logic                     rd_valid_o,
    output logic [DW-1:0]            rd_data_o,
    output logic [AW-1:0]            mem_addr_o,
    output logic [DW-1:0]            mem_wdata_o,
    output logic                     Mem_Read_o,
    output logic                     Mem_Write_o,
    input  logic [DW-1:0]            mem_rdata_i,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    r_addr [DEPTH];
    logic [DW-1:0]    r_data [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic             r_rd_valid;
    logic [DW-1:0]    r_rd_data;

    logic             w_ready;
    logic             w_acc;
    logic             w_st;
    logic             w_ld;
    logic             w_hit;
    logic [DW-1:0]    w_fwd;
    logic [PW-1:0]    w_idx;
    logic             w_miss;
    logic             w_drain;

    // Accept decode; ready depends only on registered occupancy
    always_comb begin
        w_ready = (r_count != CW'(DEPTH));
        w_acc   = req_valid_i & w_ready;
        w_st    = w_acc & req_write_i;
        w_ld    = w_acc & ~req_write_i;
    end

    // Scan entries oldest to youngest from head so the last match is the youngest
    always_comb begin
        w_hit = 1'b0;
        w_fwd = '0;
        w_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_head + PW'(k);
            if (r_vld[w_idx] && (r_addr[w_idx] == req_addr_i)) begin
                w_hit = 1'b1;
                w_fwd = r_data[w_idx];
            end
        end
    end

    // Port arbitration: a load miss owns the memory port, otherwise drain the head
    always_comb begin
        w_miss      = w_ld & ~w_hit;
        w_drain     = (r_count != '0) & ~w_miss;
        Mem_Read_o  = w_miss;
        Mem_Write_o = w_drain;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (w_miss) begin
            mem_addr_o = req_addr_i;
        end else if (w_drain) begin
            mem_addr_o  = r_addr[r_head];
            mem_wdata_o = r_data[r_head];
        end
    end

    // Pointer, valid-mask and occupancy bookkeeping
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_vld   <= '0;
        end else begin
            if (w_st) begin
                r_tail        <= r_tail + PW'(1);
                r_vld[r_tail] <= 1'b1;
            end
            if (w_drain) begin
                r_head        <= r_head + PW'(1);
                r_vld[r_head] <= 1'b0;
            end
            case ({w_st, w_drain})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry payload; validity is tracked separately so no reset is needed here
    always_ff @(posedge clk_i) begin
        if (w_st) begin
            r_addr[r_tail] <= req_addr_i;
            r_data[r_tail] <= req_wdata_i;
        end
    end

    // Registered load response: forwarded data on a hit, memory data on a miss
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_ld;
            if (w_ld) begin
                r_rd_data <= w_hit ? w_fwd : mem_rdata_i;
            end
        end
    end

    assign req_ready_o = w_ready;
    assign rd_valid_o  = r_rd_valid;
    assign rd_data_o   = r_rd_data;
    assign empty_o     = (r_count == '0);
    assign count_o     = r_count;

endmodule

// File: tb/tb_mem_store_buffer.sv
// Self-checking bench for mem_store_buffer.
// Queue-based reference model plus a behavioural Data_Memory.
module tb_mem_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_write_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic        req_ready_o;
    logic        rd_valid_o;
    logic [31:0] rd_data_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        Mem_Read_o;
    logic        Mem_Write_o;
    logic [31:0] mem_rdata_i;
    logic        empty_o;
    logic [2:0]  count_o;

    mem_store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_write_i (req_write_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_ready_o (req_ready_o),
        .rd_valid_o  (rd_valid_o),
        .rd_data_o   (rd_data_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .Mem_Read_o  (Mem_Read_o),
        .Mem_Write_o (Mem_Write_o),
        .mem_rdata_i (mem_rdata_i),
        .empty_o     (empty_o),
        .count_o     (count_o)
    );

    always #5 clk = ~clk;

    // Behavioural Data_Memory: combinational read, write at the edge
    logic [31:0] dmem [0:255] = '{16: 32'h12345678, default: 32'h0};
    assign mem_rdata_i = dmem[mem_addr_o[9:2]];
    always @(posedge clk) begin
        if (Mem_Write_o === 1'b1) dmem[mem_addr_o[9:2]] <= mem_wdata_o;
    end

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } port_t;

    typedef struct packed {
        logic        rv;
        logic [31:0] rdata;
        logic [2:0]  cnt;
        logic        emp;
        logic        rdy;
    } regs_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    // Reference model state
    ent_t        q[$];
    logic [31:0] mmem [0:255] = '{16: 32'h12345678, default: 32'h0};
    logic        m_rv = 1'b0;
    logic [31:0] m_rd = '0;

    port_t exp_p, obs_p;
    regs_t exp_r, obs_r;
    int    checks = 0;
    int    passes = 0;

    // One clock of stimulus; model predicts port outputs and post-edge state
    task automatic step(input logic rst, input logic v, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
        bit          acc, hit, miss, drain;
        logic [31:0] fwd;
        ent_t        h, e;
        @(negedge clk);
        rst_i = rst;
        req_valid_i = v;
        req_write_i = w;
        req_addr_i = a;
        req_wdata_i = d;
        acc = v && (q.size() != DEPTH);
        hit = 0;
        fwd = '0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (!hit && q[i].a == a) begin
                hit = 1;
                fwd = q[i].d;
            end
        end
        miss = acc && !w && !hit;
        drain = (q.size() > 0) && !miss;
        h = '0;
        if (q.size() > 0) h = q[0];
        exp_p.rd = miss;
        exp_p.wr = drain;
        exp_p.addr = miss ? a : (drain ? h.a : 32'h0);
        exp_p.wdata = drain ? h.d : 32'h0;
        #2;
        obs_p = {Mem_Read_o, Mem_Write_o, mem_addr_o, mem_wdata_o};
        @(posedge clk);
        m_rv = acc && !w;
        if (acc && !w) m_rd = hit ? fwd : mmem[a[9:2]];
        if (drain) begin
            mmem[h.a[9:2]] = h.d;
            void'(q.pop_front());
        end
        if (acc && w) begin
            e.a = a;
            e.d = d;
            q.push_back(e);
        end
        if (!rst) begin
            q.delete();
            m_rv = 1'b0;
            m_rd = '0;
        end
        #1;
        exp_r = {m_rv, m_rd, 3'(q.size()), q.size() == 0, q.size() != DEPTH};
        obs_r = {rd_valid_o, rd_data_o, count_o, empty_o, req_ready_o};
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++;
        if (obs_r !== exp_r) $display("FAIL reset regs: got %h want %h", obs_r, exp_r);
        else passes++;
        step(1'b0, 1'b1, 1'b1, 32'h50, 32'h99);
        checks++;
        if (obs_p !== exp_p) $display("FAIL reset port: got %h want %h", obs_p, exp_p);
        else passes++;
        checks++;
        if (obs_r !== 71'h0_0000_0000_03 || obs_r !== exp_r)
            $display("FAIL reset dominates: got %h want %h", obs_r, exp_r);
        else passes++;
    endtask

    task automatic test_store_drain();
        step(1'b1, 1'b1, 1'b1, 32'h10, 32'hAAAA5555);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++;
        if (obs_p !== exp_p || obs_p !== {1'b0, 1'b1, 32'h10, 32'hAAAA5555})
            $display("FAIL store_drain port: got %h want %h", obs_p, exp_p);
        else passes++;
        checks++;
        if (obs_r !== exp_r || obs_r.emp !== 1'b1)
            $display("FAIL store_drain empty: got %h want %h", obs_r, exp_r);
        else passes++;
    endtask

    task automatic test_fill();
        logic [31:0] sa;
        for (int i = 0; i < 4; i++) begin
            sa = 32'(i * 4);
            step(1'b1, 1'b1, 1'b1, sa, 32'hC0DE0000 + sa);
            checks++;
            if (obs_p !== exp_p) $display("FAIL fill st port %0d: got %h want %h", i, obs_p, exp_p);
            else passes++;
            step(1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
            checks++;
            if (obs_p !== exp_p) $display("FAIL fill ld port %0d: got %h want %h", i, obs_p, exp_p);
            else passes++;
            checks++;
            if (obs_r !== exp_r) $display("FAIL fill ld regs %0d: got %h want %h", i, obs_r, exp_r);
            else passes++;
        end
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++;
        if (obs_r !== exp_r) $display("FAIL fill idle regs: got %h want %h", obs_r, exp_r);
        else passes++;
    endtask

    task automatic test_forward();
        step(1'b1, 1'b1, 1'b1, 32'h20, 32'h1);
        step(1'b1, 1'b1, 1'b1, 32'h20, 32'h2);
        step(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
        checks++;
        if (obs_p !== exp_p || obs_p.rd !== 1'b0)
            $display("FAIL forward port: got %h want %h", obs_p, exp_p);
        else passes++;
        checks++;
        if (obs_r !== exp_r || obs_r.rdata !== 32'h2 || obs_r.rv !== 1'b1)
            $display("FAIL forward data: got %h want %h", obs_r, exp_r);
        else passes++;
    endtask

    task automatic test_load_miss();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
        checks++;
        if (obs_p !== exp_p || obs_p.rd !== 1'b1 || obs_p.addr !== 32'h40)
            $display("FAIL load_miss port: got %h want %h", obs_p, exp_p);
        else passes++;
        checks++;
        if (obs_r !== exp_r || obs_r.rdata !== 32'h12345678)
            $display("FAIL load_miss data: got %h want %h", obs_r, exp_r);
        else passes++;
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++;
        if (obs_r.rv !== 1'b0 || obs_r !== exp_r)
            $display("FAIL rd_valid pulse: got %h want %h", obs_r, exp_r);
        else passes++;
    endtask

    task automatic test_hit_drain();
        step(1'b1, 1'b1, 1'b1, 32'h30, 32'h7);
        step(1'b1, 1'b1, 1'b0, 32'h30, 32'h0);
        checks++;
        if (obs_p !== exp_p || obs_p.wr !== 1'b1 || obs_p.addr !== 32'h30)
            $display("FAIL hit_drain port: got %h want %h", obs_p, exp_p);
        else passes++;
        checks++;
        if (obs_r !== exp_r || obs_r.rdata !== 32'h7 || obs_r.cnt !== 3'd0)
            $display("FAIL hit_drain regs: got %h want %h", obs_r, exp_r);
        else passes++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 32'h80 + 32'(i * 4), 32'(i + 100));
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++;
        if (obs_r !== exp_r || obs_r.cnt !== 3'd0 || obs_r.rv !== 1'b0)
            $display("FAIL reset_mid regs: got %h want %h", obs_r, exp_r);
        else passes++;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
            checks++;
            if (obs_p !== exp_p || obs_p.wr !== 1'b0)
                $display("FAIL reset_mid idle %0d: got %h want %h", i, obs_p, exp_p);
            else passes++;
        end
        for (int i = 0; i < 8; i++) begin
            if (i < 6) step(1'b1, 1'b1, 1'b1, 32'hC0 + 32'(i * 4), 32'(i + 500));
            else step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
            checks++;
            if (obs_p !== exp_p) $display("FAIL wrap port %0d: got %h want %h", i, obs_p, exp_p);
            else passes++;
            checks++;
            if (obs_r !== exp_r) $display("FAIL wrap regs %0d: got %h want %h", i, obs_r, exp_r);
            else passes++;
        end
    endtask

    task automatic test_random();
        logic v, w;
        logic [31:0] a;
        for (int i = 0; i < 300; i++) begin
            v = ($urandom_range(0, 3) != 0);
            w = $urandom_range(0, 1) == 1;
            a = 32'($urandom_range(0, 15)) << 2;
            step(1'b1, v, w, a, $urandom);
            checks++;
            if (obs_p !== exp_p) $display("FAIL random port %0d: got %h want %h", i, obs_p, exp_p);
            else passes++;
            checks++;
            if (obs_r !== exp_r) $display("FAIL random regs %0d: got %h want %h", i, obs_r, exp_r);
            else passes++;
        end
    endtask

    task automatic test_memory();
        int bad;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        bad = 0;
        for (int i = 0; i < 256; i++) if (dmem[i] !== mmem[i]) bad++;
        checks++;
        if (bad != 0 || q.size() != 0)
            $display("FAIL memory image: got %0d differing words want 0", bad);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_store_drain();
        test_fill();
        test_forward();
        test_load_miss();
        test_hit_drain();
        test_reset_mid();
        test_random();
        test_memory();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
